// File: rtl/pll_reset_supervisor.sv
// PLL reset sequencer and lock qualifier running on the free-running reference clock.
// Releases the system reset only after the PLL lock has stayed stable, and re-resets the PLL when lock is lost.
module pll_reset_supervisor #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 100000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int CNT_W               = 17
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic       ready,
  output logic [7:0] relock_count,
  output logic [7:0] timeout_count
);

  typedef enum logic [1:0] {
    ST_RESET_PLL  = 2'd0,
    ST_WAIT_LOCK  = 2'd1,
    ST_STABILIZE  = 2'd2,
    ST_RUN        = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};

  state_t           state_r, state_next_s;
  logic [CNT_W-1:0] cnt_r, cnt_next_s;
  logic             sync_meta_r, locked_sync_r;
  logic [7:0]       relock_r, relock_next_s;
  logic [7:0]       timeout_r, timeout_next_s;
  logic             pll_rst_r, sys_reset_r, ready_r;

  // Debug counts stop at 255 rather than wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    if (val == 8'd255) begin
      return val;
    end else begin
      return val + 8'd1;
    end
  endfunction

  // Two-flop synchronizer for the asynchronous lock indicator.
  always_ff @(posedge refclk) begin
    if (rst) begin
      sync_meta_r   <= 1'b0;
      locked_sync_r <= 1'b0;
    end else begin
      sync_meta_r   <= pll_locked;
      locked_sync_r <= sync_meta_r;
    end
  end

  // Next-state, counter and event-count logic.
  always_comb begin
    state_next_s   = state_r;
    cnt_next_s     = cnt_r;
    relock_next_s  = relock_r;
    timeout_next_s = timeout_r;
    case (state_r)
      ST_RESET_PLL: begin
        if (cnt_r == PULSE_LAST) begin
          state_next_s = ST_WAIT_LOCK;
          cnt_next_s   = CNT_ZERO;
        end else begin
          cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_WAIT_LOCK: begin
        // Lock arriving on the timeout cycle takes priority over the timeout.
        if (locked_sync_r) begin
          state_next_s = ST_STABILIZE;
          cnt_next_s   = CNT_ZERO;
        end else if (cnt_r == TIMEOUT_LAST) begin
          state_next_s   = ST_RESET_PLL;
          cnt_next_s     = CNT_ZERO;
          timeout_next_s = sat_inc8(timeout_r);
        end else begin
          cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_STABILIZE: begin
        if (!locked_sync_r) begin
          state_next_s = ST_WAIT_LOCK;
          cnt_next_s   = CNT_ZERO;
        end else if (cnt_r == STABLE_LAST) begin
          state_next_s = ST_RUN;
          cnt_next_s   = CNT_ZERO;
        end else begin
          cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_RUN: begin
        if (!locked_sync_r) begin
          state_next_s  = ST_RESET_PLL;
          cnt_next_s    = CNT_ZERO;
          relock_next_s = sat_inc8(relock_r);
        end else begin
          state_next_s = ST_RUN;
        end
      end
      default: begin
        state_next_s = ST_RESET_PLL;
        cnt_next_s   = CNT_ZERO;
      end
    endcase
  end

  // State, counters and output flops; outputs are decoded from the next state so they track the state register.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_r     <= ST_RESET_PLL;
      cnt_r       <= CNT_ZERO;
      relock_r    <= 8'd0;
      timeout_r   <= 8'd0;
      pll_rst_r   <= 1'b1;
      sys_reset_r <= 1'b1;
      ready_r     <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      cnt_r       <= cnt_next_s;
      relock_r    <= relock_next_s;
      timeout_r   <= timeout_next_s;
      pll_rst_r   <= (state_next_s == ST_RESET_PLL);
      sys_reset_r <= (state_next_s != ST_RUN);
      ready_r     <= (state_next_s == ST_RUN);
    end
  end

  assign pll_rst       = pll_rst_r;
  assign sys_reset     = sys_reset_r;
  assign ready         = ready_r;
  assign relock_count  = relock_r;
  assign timeout_count = timeout_r;

endmodule

// File: tb/tb_pll_reset_supervisor.sv
// Directed bench for pll_reset_supervisor with short cycle parameters (4/32/8, 6-bit counter).
module tb_pll_reset_supervisor;

  logic       refclk;
  logic       rst;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_reset;
  logic       ready;
  logic [7:0] relock_count;
  logic [7:0] timeout_count;

  int checks_r;
  int failures_r;

  pll_reset_supervisor #(
    .RST_PULSE_CYCLES   (4),
    .LOCK_TIMEOUT_CYCLES(32),
    .LOCK_STABLE_CYCLES (8),
    .CNT_W              (6)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .pll_rst      (pll_rst),
    .sys_reset    (sys_reset),
    .ready        (ready),
    .relock_count (relock_count),
    .timeout_count(timeout_count)
  );

  // 50 MHz reference clock.
  initial begin
    refclk = 1'b0;
    forever #10 refclk = ~refclk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_r++;
    if (obs !== exp) begin
      failures_r++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic hold_reset(input logic lock_val);
    pll_locked = lock_val;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  // With lock present during reset: pll_rst high through edge 3, RUN at edge 13.
  task automatic check_powerup(input string pfx);
    for (int k = 1; k <= 13; k++) begin
      tick();
      check_eq({pfx, "_pll_rst"}, 32'(pll_rst), 32'(k <= 3));
      check_eq({pfx, "_sys_reset"}, 32'(sys_reset), 32'(k < 13));
      check_eq({pfx, "_ready"}, 32'(ready), 32'(k >= 13));
    end
    check_eq({pfx, "_relock"}, 32'(relock_count), 32'd0);
    check_eq({pfx, "_timeout"}, 32'(timeout_count), 32'd0);
  endtask

  initial begin
    checks_r   = 0;
    failures_r = 0;
    rst        = 1'b1;
    pll_locked = 1'b1;

    // Reset state and clean power-up.
    hold_reset(1'b1);
    check_eq("rst_pll_rst", 32'(pll_rst), 32'd1);
    check_eq("rst_sys_reset", 32'(sys_reset), 32'd1);
    check_eq("rst_ready", 32'(ready), 32'd0);
    check_eq("rst_relock", 32'(relock_count), 32'd0);
    check_eq("rst_timeout", 32'(timeout_count), 32'd0);
    check_powerup("s1");

    // Lock loss in RUN; lock restored right after the supervisor reacts.
    pll_locked = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 3) pll_locked = 1'b1;
      check_eq("s4_ready", 32'(ready), 32'(k < 3 || k >= 16));
      check_eq("s4_pll_rst", 32'(pll_rst), 32'(k >= 3 && k <= 6));
    end
    check_eq("s4_relock", 32'(relock_count), 32'd1);
    check_eq("s4_timeout", 32'(timeout_count), 32'd0);

    // Reset from RUN: sys_reset rises one edge later and counts clear.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("runrst_sys_reset", 32'(sys_reset), 32'd1);
    check_eq("runrst_pll_rst", 32'(pll_rst), 32'd1);
    check_eq("runrst_relock", 32'(relock_count), 32'd0);

    // One-cycle lock glitch during STABILIZE.
    hold_reset(1'b1);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 8) pll_locked = 1'b0;
      if (k == 9) pll_locked = 1'b1;
      check_eq("s3_ready", 32'(ready), 32'(k >= 20));
      if (k >= 4) check_eq("s3_pll_rst", 32'(pll_rst), 32'd0);
    end
    check_eq("s3_relock", 32'(relock_count), 32'd0);
    check_eq("s3_timeout", 32'(timeout_count), 32'd0);

    // Lock reaches the FSM exactly on the timeout cycle: lock wins.
    hold_reset(1'b0);
    for (int k = 1; k <= 44; k++) begin
      tick();
      if (k == 33) pll_locked = 1'b1;
      if (k >= 4) check_eq("s6_pll_rst", 32'(pll_rst), 32'd0);
      check_eq("s6_ready", 32'(ready), 32'(k >= 44));
    end
    check_eq("s6_timeout", 32'(timeout_count), 32'd0);

    // Mid-operation reset in WAIT_LOCK with three timeouts recorded.
    hold_reset(1'b0);
    repeat (118) tick();
    check_eq("s5_timeout_pre", 32'(timeout_count), 32'd3);
    check_eq("s5_pll_rst_pre", 32'(pll_rst), 32'd0);
    pll_locked = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("s5_timeout_clr", 32'(timeout_count), 32'd0);
    check_eq("s5_pll_rst", 32'(pll_rst), 32'd1);
    check_powerup("s5");

    // No lock at all: periodic PLL reset pulses and saturating timeout count.
    hold_reset(1'b0);
    for (int k = 1; k <= 10800; k++) begin
      tick();
      if (k <= 80) check_eq("s2_pll_rst", 32'(pll_rst), 32'(k <= 3 || (k % 36) <= 3));
      if (k == 35)    check_eq("s2_timeout_35", 32'(timeout_count), 32'd0);
      if (k == 36)    check_eq("s2_timeout_36", 32'(timeout_count), 32'd1);
      if (k == 72)    check_eq("s2_timeout_72", 32'(timeout_count), 32'd2);
      if (k == 9179)  check_eq("s2_timeout_254", 32'(timeout_count), 32'd254);
      if (k == 9180)  check_eq("s2_timeout_255", 32'(timeout_count), 32'd255);
      if (k == 10800) check_eq("s2_timeout_sat", 32'(timeout_count), 32'd255);
      if (k == 10800) check_eq("s2_sys_reset", 32'(sys_reset), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
    $finish;
  end

endmodule

// File: doc/pll_reset_supervisor.md
Name: pll_reset_supervisor

Overview:
- Drives the PLL `rst` input and consumes its `locked` output.
- Sequences PLL reset, waits for lock, and qualifies lock stability before releasing the design-wide synchronous reset.
- Runs on the free-running 50 MHz `refclk`, never on a PLL output.
- On lock loss or lock timeout it re-resets the PLL, holds the system in reset, and keeps saturating event counters for debug/OSD readout.

Parameters:
- RST_PULSE_CYCLES, 16: refclk cycles `pll_rst` is held high per reset pulse (≥1).
- LOCK_TIMEOUT_CYCLES, 100000: refclk cycles to wait for lock before re-pulsing PLL reset (2 ms at 50 MHz).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-locked cycles required before releasing `sys_reset`.
- CNT_W, 17: width of the shared cycle counter; must hold max(all cycle parameters)−1.

Ports:
- refclk  in  1  free-running reference clock; sole clock of this block.
- rst  in  1  synchronous, active-high reset.
- pll_locked  in  1  PLL lock indicator; asynchronous to refclk.
- pll_rst  out  1  reset to the PLL, active high.
- sys_reset  out  1  synchronous active-high reset to the rest of the design.
- ready  out  1  high while clocks are qualified (state RUN).
- relock_count  out  8  number of lock losses seen in RUN; saturates at 255.
- timeout_count  out  8  number of lock-wait timeouts; saturates at 255.

Behaviour:
- Clocking and reset:
  - One clock: `refclk`.
  - Reset is synchronous and active-high on `rst`.
  - While `rst`=1: state=RESET_PLL, counter=0, sync flops=0, relock_count=0, timeout_count=0.
- Outputs are Moore-decoded from the state register, so there are no combinational paths from inputs:
  - pll_rst = (state==RESET_PLL)
  - sys_reset = (state!=RUN)
  - ready = (state==RUN)
  - During reset: pll_rst=1, sys_reset=1, ready=0, both counts 0.
- pll_locked passes through a 2-flop synchronizer (locked_s). This adds 2 cycles latency, and the FSM sees only locked_s.
- States:
  - RESET_PLL:
    - counter increments each cycle.
    - When counter==RST_PULSE_CYCLES−1: go to WAIT_LOCK, counter=0.
    - locked_s is ignored in this state.
  - WAIT_LOCK:
    - If locked_s=1: go to STABILIZE, counter=0.
    - Else if counter==LOCK_TIMEOUT_CYCLES−1: go to RESET_PLL, counter=0, timeout_count+1 (saturating).
    - Else counter+1.
  - STABILIZE:
    - If locked_s=0: go to WAIT_LOCK, counter=0. No PLL reset is issued and no counter is bumped (treated as a lock glitch).
    - Else if counter==LOCK_STABLE_CYCLES−1: go to RUN.
    - Else counter+1.
  - RUN:
    - If locked_s=0: go to RESET_PLL, counter=0, relock_count+1 (saturating).
    - Otherwise hold.
- Timing:
  - Worst-case lock-loss to sys_reset=1 is 3 refclk cycles: 2 synchronizer + 1 state register.
  - From the first edge with rst=0 and lock already present, RUN is entered after RST_PULSE_CYCLES + 1 + LOCK_STABLE_CYCLES edges.
- Simultaneous events:
  - rst has priority over every transition.
  - A lock-wait timeout and lock arriving on the same cycle: lock wins, go to STABILIZE.
  - Count saturation: at 255 the count holds; no wrap.
- Reset mid-operation: rst in any state forces RESET_PLL on the next edge. sys_reset is already 1 in every state except RUN, and rises one edge later from RUN.

Test Plan:
All scenarios use RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, CNT_W=6.

1. Clean power-up: pll_locked=1 throughout, release rst → pll_rst=1 for exactly 4 cycles, ready/sys_reset flip exactly 13 edges after release, both counts 0.
2. No lock: pll_locked=0 permanently → pll_rst pulses 4 high / 32 low periodically, timeout_count increments each pulse, sys_reset stays 1; after 300 timeouts timeout_count=255.
3. Glitch during STABILIZE: drop pll_locked for 1 cycle midway through stabilization → no pll_rst pulse, stable count restarts, RUN reached 8+ cycles after locked_s returns, counts unchanged.
4. Lock loss in RUN: drop pll_locked → sys_reset=1 and ready=0 within 3 edges, pll_rst=1 for 4 cycles, relock_count=1; with lock restored, RUN re-entered after 4+1+8 cycles plus synchronizer delay.
5. Mid-operation reset: assert rst for 1 cycle while in WAIT_LOCK with timeout_count=3 → counts cleared to 0, pll_rst=1, sequence restarts exactly as in scenario 1.
6. Tie at timeout: locked_s rises on the same edge the wait counter reaches 31 → enters STABILIZE, timeout_count not incremented, no pll_rst pulse.
